// File: rtl/jt1943_dwnld.sv
`default_nettype none
// ============================================================================
//  Module   : jt1943_dwnld
//  Purpose  : Sorts the ioctl download stream into linear/GFX-interleaved
//             SDRAM writes (held-request/ack with skid buffer) and PROM writes.
//  Revision : 1.0  initial release
// ============================================================================
module jt1943_dwnld #(
    parameter logic [21:0] GFX_START  = 22'h08_0000,
    parameter int          GFX_AW     = 17,
    parameter logic [21:0] PROM_START = 22'h0C_0000,
    parameter int          PROMS      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic              ioctl_wr,
    input  logic [21:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    output logic              prog_we,
    output logic [21:0]       prog_addr,
    output logic [7:0]        prog_data,
    output logic [1:0]        prog_mask,
    input  logic              prog_ack,
    output logic [PROMS-1:0]  prom_we,
    output logic [7:0]        prom_addr,
    output logic [7:0]        prom_din,
    output logic              dwnld_busy,
    output logic              dwnld_done,
    output logic              overflow
);

    localparam logic [0:0]  c_ST_IDLE    = 1'b0;
    localparam logic [0:0]  c_ST_REQ     = 1'b1;
    localparam logic [21:0] c_GFX_WORD   = GFX_START >> 1;
    localparam logic [21:0] c_PROM_BYTES = 22'(PROMS * 256);
    localparam logic [PROMS-1:0] c_PROM_ONE = {{(PROMS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Address translation
    // ------------------------------------------------------------------
    logic              w_wr;
    logic              w_is_prom;
    logic              w_is_gfx;
    logic [GFX_AW-1:0] w_gfx_off;
    logic [21:0]       w_gfx_word;
    logic [21:0]       w_prom_off;
    logic              w_prom_hit;
    logic              w_sd_in;
    logic [21:0]       w_in_addr;
    logic [1:0]        w_in_mask;

    assign w_wr       = downloading & ioctl_wr;
    assign w_is_prom  = (ioctl_addr >= PROM_START);
    assign w_is_gfx   = (ioctl_addr >= GFX_START) & ~w_is_prom;
    assign w_gfx_off  = ioctl_addr[GFX_AW-1:0] - GFX_START[GFX_AW-1:0];
    // Top offset bit selects the lane; the lower half-region picks the word
    assign w_gfx_word = c_GFX_WORD + {{(23-GFX_AW){1'b0}}, w_gfx_off[GFX_AW-2:0]};
    assign w_prom_off = ioctl_addr - PROM_START;
    assign w_prom_hit = w_wr & w_is_prom & (w_prom_off < c_PROM_BYTES);
    assign w_sd_in    = w_wr & ~w_is_prom;

    always_comb begin
        w_in_addr = {1'b0, ioctl_addr[21:1]};
        w_in_mask = ioctl_addr[0] ? 2'b01 : 2'b10;
        if (w_is_gfx) begin
            w_in_addr = w_gfx_word;
            w_in_mask = w_gfx_off[GFX_AW-1] ? 2'b01 : 2'b10;
        end
    end

    // ------------------------------------------------------------------
    // PROM write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prom_we   <= '0;
            prom_addr <= 8'h00;
            prom_din  <= 8'h00;
        end else begin
            prom_we <= w_prom_hit ? (c_PROM_ONE << w_prom_off[11:8]) : '0;
            if (w_prom_hit) begin
                prom_addr <= w_prom_off[7:0];
                prom_din  <= ioctl_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // SDRAM request FSM with one-entry skid buffer
    // ------------------------------------------------------------------
    logic [0:0]  r_state,     w_state_nxt;
    logic        r_buf_valid, w_buf_valid_nxt;
    logic [21:0] r_buf_addr,  w_buf_addr_nxt;
    logic [7:0]  r_buf_data,  w_buf_data_nxt;
    logic [1:0]  r_buf_mask,  w_buf_mask_nxt;
    logic        w_we_nxt;
    logic [21:0] w_addr_nxt;
    logic [7:0]  w_data_nxt;
    logic [1:0]  w_mask_nxt;
    logic        w_ovf_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_addr_nxt  = r_buf_addr;
        w_buf_data_nxt  = r_buf_data;
        w_buf_mask_nxt  = r_buf_mask;
        w_we_nxt        = prog_we;
        w_addr_nxt      = prog_addr;
        w_data_nxt      = prog_data;
        w_mask_nxt      = prog_mask;
        w_ovf_nxt       = overflow;
        case (r_state)
            c_ST_IDLE: begin
                if (w_sd_in) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = w_in_addr;
                    w_data_nxt  = ioctl_data;
                    w_mask_nxt  = w_in_mask;
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (prog_ack) begin
                    if (r_buf_valid) begin
                        w_addr_nxt = r_buf_addr;
                        w_data_nxt = r_buf_data;
                        w_mask_nxt = r_buf_mask;
                        if (w_sd_in) begin
                            w_buf_addr_nxt = w_in_addr;
                            w_buf_data_nxt = ioctl_data;
                            w_buf_mask_nxt = w_in_mask;
                        end else begin
                            w_buf_valid_nxt = 1'b0;
                        end
                    end else if (w_sd_in) begin
                        // Empty buffer drains straight onto the outputs
                        w_addr_nxt = w_in_addr;
                        w_data_nxt = ioctl_data;
                        w_mask_nxt = w_in_mask;
                    end else begin
                        w_we_nxt    = 1'b0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (w_sd_in) begin
                    if (!r_buf_valid) begin
                        w_buf_valid_nxt = 1'b1;
                        w_buf_addr_nxt  = w_in_addr;
                        w_buf_data_nxt  = ioctl_data;
                        w_buf_mask_nxt  = w_in_mask;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= 22'h0;
            r_buf_data  <= 8'h00;
            r_buf_mask  <= 2'b11;
            prog_we     <= 1'b0;
            prog_addr   <= 22'h0;
            prog_data   <= 8'h00;
            prog_mask   <= 2'b11;
            overflow    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_addr  <= w_buf_addr_nxt;
            r_buf_data  <= w_buf_data_nxt;
            r_buf_mask  <= w_buf_mask_nxt;
            prog_we     <= w_we_nxt;
            prog_addr   <= w_addr_nxt;
            prog_data   <= w_data_nxt;
            prog_mask   <= w_mask_nxt;
            overflow    <= w_ovf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Completion tracking
    // ------------------------------------------------------------------
    logic r_seen;

    assign dwnld_busy = downloading | prog_we | r_buf_valid;
    assign dwnld_done = r_seen & ~downloading & ~prog_we & ~r_buf_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen <= 1'b0;
        end else if (downloading) begin
            r_seen <= 1'b1;
        end else if (dwnld_done) begin
            r_seen <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt1943_dwnld.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt1943_dwnld
//  Purpose  : Scoreboard bench for jt1943_dwnld download translator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jt1943_dwnld;

    localparam logic [21:0] c_GFX_START  = 22'h08_0000;
    localparam logic [21:0] c_PROM_START = 22'h0C_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [21:0] ioctl_addr = 22'h0;
    logic [7:0]  ioctl_data = 8'h00;
    logic        prog_we;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_ack = 1'b0;
    logic [11:0] prom_we;
    logic [7:0]  prom_addr;
    logic [7:0]  prom_din;
    logic        dwnld_busy;
    logic        dwnld_done;
    logic        overflow;

    jt1943_dwnld dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_ack    (prog_ack),
        .prom_we     (prom_we),
        .prom_addr   (prom_addr),
        .prom_din    (prom_din),
        .dwnld_busy  (dwnld_busy),
        .dwnld_done  (dwnld_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [21:0] a; logic [7:0] d; logic [1:0] m; } sd_t;
    typedef struct packed { logic [11:0] we; logic [7:0] a; logic [7:0] d; } pr_t;
    sd_t sd_q[$];
    pr_t pr_q[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Monitor: each accepted SDRAM request and each PROM strobe pops the scoreboard
    always @(negedge clk) begin
        sd_t e;
        pr_t p;
        if (!rst) begin
            if (prog_we && prog_ack) begin
                if (sd_q.size() == 0) begin
                    chk("sd_unexpected_write", 32'(sd_q.size()), 1);
                end else begin
                    e = sd_q.pop_front();
                    chk("sd_addr", 32'(prog_addr), 32'(e.a));
                    chk("sd_data", 32'(prog_data), 32'(e.d));
                    chk("sd_mask", 32'(prog_mask), 32'(e.m));
                end
            end
            if (prom_we != 12'h000) begin
                if (pr_q.size() == 0) begin
                    chk("prom_unexpected_write", 32'(pr_q.size()), 1);
                end else begin
                    p = pr_q.pop_front();
                    chk("prom_we", 32'(prom_we), 32'(p.we));
                    chk("prom_addr", 32'(prom_addr), 32'(p.a));
                    chk("prom_din", 32'(prom_din), 32'(p.d));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack_one();
        prog_ack = 1'b1;
        step();
        prog_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_prog_we", 32'(prog_we), 0);
        chk("rst_prog_addr", 32'(prog_addr), 0);
        chk("rst_prog_data", 32'(prog_data), 0);
        chk("rst_prog_mask", 32'(prog_mask), 32'h3);
        chk("rst_prom_we", 32'(prom_we), 0);
        chk("rst_prom_addr", 32'(prom_addr), 0);
        chk("rst_prom_din", 32'(prom_din), 0);
        chk("rst_busy", 32'(dwnld_busy), 0);
        chk("rst_done", 32'(dwnld_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        step();
        rst = 1'b0;

        // Strobe outside the download window is ignored
        send(22'h00_0005, 8'hFF);
        @(negedge clk);
        chk("idle_wr_ignored", 32'(prog_we), 0);

        // Linear byte, ack three cycles after the request appears
        step();
        downloading = 1'b1;
        step();
        sd_q.push_back('{a: 22'h00_0002, d: 8'hA5, m: 2'b01});
        send(22'h00_0005, 8'hA5);
        @(negedge clk);
        chk("lin_we", 32'(prog_we), 1);
        chk("lin_addr", 32'(prog_addr), 32'h2);
        chk("lin_mask", 32'(prog_mask), 32'h1);
        chk("lin_data", 32'(prog_data), 32'hA5);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk("lin_hold_we", 32'(prog_we), 1);
            chk("lin_hold_addr", 32'(prog_addr), 32'h2);
        end
        step();
        ack_one();
        @(negedge clk);
        chk("lin_we_fall", 32'(prog_we), 0);

        // GFX interleave: both halves land on the same word, opposite lanes
        step();
        sd_q.push_back('{a: 22'h04_0010, d: 8'h11, m: 2'b10});
        send(c_GFX_START + 22'h0_0010, 8'h11);
        @(negedge clk);
        chk("gfx_lo_addr", 32'(prog_addr), 32'h4_0010);
        chk("gfx_lo_mask", 32'(prog_mask), 32'h2);
        step();
        ack_one();
        sd_q.push_back('{a: 22'h04_0010, d: 8'h22, m: 2'b01});
        send(c_GFX_START + 22'h1_0010, 8'h22);
        @(negedge clk);
        chk("gfx_hi_mask", 32'(prog_mask), 32'h1);
        step();
        ack_one();

        // PROM bank 3 write, then an out-of-range PROM byte
        pr_q.push_back('{we: 12'b0000_0000_1000, a: 8'h05, d: 8'h3C});
        send(c_PROM_START + 22'h0_0305, 8'h3C);
        @(negedge clk);
        chk("prom_strobe", 32'(prom_we), 32'h008);
        chk("prom_no_sdram", 32'(prog_we), 0);
        step();
        @(negedge clk);
        chk("prom_one_cycle", 32'(prom_we), 0);
        step();
        send(c_PROM_START + 22'h0_0C00, 8'h77);
        @(negedge clk);
        chk("prom_oob_drop", 32'(prom_we), 0);
        chk("prom_oob_no_sdram", 32'(prog_we), 0);

        // Skid buffer fills, third byte lost
        step();
        sd_q.push_back('{a: 22'h00_0080, d: 8'h01, m: 2'b10});
        sd_q.push_back('{a: 22'h00_0080, d: 8'h02, m: 2'b01});
        send(22'h00_0100, 8'h01);
        send(22'h00_0101, 8'h02);
        send(22'h00_0102, 8'h03);
        @(negedge clk);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_head_data", 32'(prog_data), 32'h01);
        chk("ovf_busy", 32'(dwnld_busy), 1);
        step();
        prog_ack = 1'b1;
        step();
        @(negedge clk);
        chk("skid_we_cont", 32'(prog_we), 1);
        chk("skid_second_data", 32'(prog_data), 32'h02);
        step();
        prog_ack = 1'b0;
        @(negedge clk);
        chk("skid_we_fall", 32'(prog_we), 0);

        // Completion waits for the final ack
        step();
        sd_q.push_back('{a: 22'h00_0100, d: 8'h5A, m: 2'b10});
        send(22'h00_0200, 8'h5A);
        downloading = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_wait", 32'(dwnld_done), 0);
            chk("busy_wait", 32'(dwnld_busy), 1);
            step();
        end
        ack_one();
        @(negedge clk);
        chk("done_pulse", 32'(dwnld_done), 1);
        chk("busy_fall", 32'(dwnld_busy), 0);
        step();
        @(negedge clk);
        chk("done_one_cycle", 32'(dwnld_done), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Reset mid-request
        step();
        downloading = 1'b1;
        send(22'h00_0300, 8'h99);
        @(negedge clk);
        chk("pre_rst_we", 32'(prog_we), 1);
        step();
        rst = 1'b1;
        downloading = 1'b0;
        step();
        @(negedge clk);
        chk("rst_mid_we", 32'(prog_we), 0);
        chk("rst_mid_ovf", 32'(overflow), 0);
        step();
        rst = 1'b0;
        step();

        chk("sd_queue_empty", 32'(sd_q.size()), 0);
        chk("prom_queue_empty", 32'(pr_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
